// File: rtl/sram_access_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------------------+
// | sram_access_arbiter : shares one async SRAM between the pixel-read and frame-fill ports |
// | Optional write-starvation guard: define SRAM_WR_STARVE_GUARD_EN.        Revision 1.0    |
// +----------------------------------------------------------------------------------------+
module sram_access_arbiter #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16,
  parameter int RD_CYC = 2,
  parameter int WR_CYC = 2
`ifdef SRAM_WR_STARVE_GUARD_EN
  ,
  parameter int STARVE_MAX = 8
`endif
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_ack,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_dq,
  output logic              o_sram_dq_oe,
  input  logic [DATA_W-1:0] i_sram_dq,
  output logic              o_sram_ce_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_we_n,
  output logic              o_busy
);

  localparam int CYC_MAX = (RD_CYC > WR_CYC) ? RD_CYC : WR_CYC;
  localparam int CNT_W   = $clog2(CYC_MAX) + 1;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYC - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_READ     = 3'd1,
    S_WR_SETUP = 3'd2,
    S_WR_PULSE = 3'd3,
    S_WR_HOLD  = 3'd4,
    S_TURN     = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rd_ack_q, rd_ack_d, wr_ack_q, wr_ack_d, rd_valid_q, rd_valid_d;
  logic              ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d, dq_oe_q, dq_oe_d;
  logic              arb_pt, grant_rd, grant_wr, wr_force;

  assign arb_pt   = (state_q == S_IDLE) || ((state_q == S_READ) && (cnt_q == RD_LAST));
  assign grant_wr = arb_pt && i_wr_req && (!i_rd_req || wr_force);
  assign grant_rd = arb_pt && i_rd_req && !grant_wr;

`ifdef SRAM_WR_STARVE_GUARD_EN
  localparam int SC_W = $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_MAX);

  logic [SC_W-1:0] starve_q, starve_d;

  // Counts reads granted past a waiting write; at the limit the write wins the next arbitration.
  assign wr_force = (starve_q == SC_MAX);

  always_comb begin
    starve_d = starve_q;
    if (!i_wr_req || grant_wr) begin
      starve_d = '0;
    end else if (grant_rd && (starve_q != SC_MAX)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`else
  assign wr_force = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    rd_ack_d   = 1'b0;
    wr_ack_d   = 1'b0;
    rd_valid_d = 1'b0;
    case (state_q)
      S_IDLE: ;
      S_READ: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == RD_LAST) begin
          rdata_d    = i_sram_dq;
          rd_valid_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      S_WR_SETUP: state_d = S_WR_PULSE;
      S_WR_PULSE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == WR_LAST) state_d = S_WR_HOLD;
      end
      S_WR_HOLD: state_d = S_TURN;
      S_TURN:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (grant_rd) begin
      state_d  = S_READ;
      cnt_d    = '0;
      addr_d   = i_rd_addr;
      rd_ack_d = 1'b1;
    end else if (grant_wr) begin
      state_d  = S_WR_SETUP;
      cnt_d    = '0;
      addr_d   = i_wr_addr;
      wdata_d  = i_wr_data;
      wr_ack_d = 1'b1;
    end
    // Pin strobes are registered from the next state so the pads never glitch.
    ce_n_d  = !(state_d inside {S_READ, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD});
    oe_n_d  = (state_d != S_READ);
    we_n_d  = (state_d != S_WR_PULSE);
    dq_oe_d = state_d inside {S_WR_SETUP, S_WR_PULSE, S_WR_HOLD};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      rd_ack_q   <= 1'b0;
      wr_ack_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      dq_oe_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      rd_ack_q   <= rd_ack_d;
      wr_ack_q   <= wr_ack_d;
      rd_valid_q <= rd_valid_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      dq_oe_q    <= dq_oe_d;
    end
  end

  assign o_rd_ack     = rd_ack_q;
  assign o_wr_ack     = wr_ack_q;
  assign o_rd_valid   = rd_valid_q;
  assign o_rd_data    = rdata_q;
  assign o_sram_addr  = addr_q;
  assign o_sram_dq    = wdata_q;
  assign o_sram_dq_oe = dq_oe_q;
  assign o_sram_ce_n  = ce_n_q;
  assign o_sram_oe_n  = oe_n_q;
  assign o_sram_we_n  = we_n_q;
  assign o_busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire
